vga_pixel_out: RTL

- Downstream consumer of the display address/fetch stage.
- Pops 25-bit words from the display FIFO. Each word holds 8 pixels at 3 bits/pixel (1 bit each R, G, B).
- Serializes the pixels at one pixel per clock.
- Generates 640x480 VGA timing (hsync, vsync, data-enable) aligned to the pixel stream.

---
 rtl/vga_pixel_out.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: unpacks 8-pixel FIFO words into a pixel stream with VGA timing.
// Video outputs trail the raster counters by two clocks to absorb FIFO read latency.
module vga_pixel_out #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int PIX_PER_WORD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [24:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic [2:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int JW = $clog2(PIX_PER_WORD);
  localparam int WW = 3 * PIX_PER_WORD;

  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);

  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nx;
  logic [VW-1:0] vcnt;
  logic [VW-1:0] vcnt_nx;

  logic run;
  logic h_act;
  logic v_act;
  logic fetch;
  logic hs_c;
  logic vs_c;
  logic fs_c;

  logic          s1_valid;
  logic          s1_fetch;
  logic          s1_pop;
  logic          s1_de;
  logic          s1_hs;
  logic          s1_vs;
  logic          s1_fs;
  logic [JW-1:0] s1_j;

  logic [WW-1:0] word_q;
  logic [WW-1:0] cur_word;
  logic [2:0]    pix [PIX_PER_WORD];

  logic unused_msb;
  assign unused_msb = ^fifo_dout[24:WW];

  assign run   = enable & ~rst;
  assign h_act = hcnt < H_ACT;
  assign v_act = vcnt < V_ACT;
  assign hs_c  = ~((hcnt >= H_SS) & (hcnt < H_SE));
  assign vs_c  = ~((vcnt >= V_SS) & (vcnt < V_SE));
  assign fs_c  = (hcnt == '0) & (vcnt == '0);

  assign fetch = run & h_act & v_act
               & (hcnt[JW-1:0] == '0);
  assign fifo_rd_en = fetch & ~fifo_empty;

  always_comb begin
    hcnt_nx = hcnt + 1'b1;
    vcnt_nx = vcnt;
    if (hcnt == H_END) begin
      hcnt_nx = '0;
      vcnt_nx = (vcnt == V_END) ? '0
                                : vcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hcnt_nx;
      vcnt <= vcnt_nx;
    end
  end

  // Stage 1: position decodes wait here while the FIFO read completes.
  always_ff @(posedge clk) begin
    if (!run) begin
      s1_valid <= 1'b0;
      s1_fetch <= 1'b0;
      s1_pop   <= 1'b0;
      s1_de    <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_fs    <= 1'b0;
      s1_j     <= '0;
    end else begin
      s1_valid <= 1'b1;
      s1_fetch <= fetch;
      s1_pop   <= fifo_rd_en;
      s1_de    <= h_act & v_act;
      s1_hs    <= hs_c;
      s1_vs    <= vs_c;
      s1_fs    <= fs_c;
      s1_j     <= hcnt[JW-1:0];
    end
  end

  // A starved slot loads zeros so its eight pixels go out black.
  always_comb begin
    cur_word = word_q;
    if (s1_fetch) begin
      cur_word = s1_pop ? fifo_dout[WW-1:0] : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      pix[i] = cur_word[3*i +: 3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else if (s1_fetch) begin
      word_q <= cur_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!run || !s1_valid) begin
      rgb         <= 3'b000;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= s1_de ? pix[s1_j] : 3'b000;
      hsync       <= s1_hs;
      vsync       <= s1_vs;
      de          <= s1_de;
      frame_start <= s1_fs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (fetch && fifo_empty) begin
      underflow <= 1'b1;
    end
  end

endmodule
